// File: rtl/sha_schedule_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha_schedule_pkg
// Purpose  : Shared SHA-256 types: round constants, schedule FSM states and
//            the working hash-state record.
// Revision : 1.0 - initial release
// ============================================================================
package sha_schedule_pkg;

    localparam int c_ROUNDS = 64;
    localparam int c_WORD   = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } hash_state_t;

    localparam logic [31:0] c_K [c_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage
`default_nettype wire

// File: rtl/sha_schedule_if.sv
`default_nettype none
// ============================================================================
// Module   : sha_schedule_if
// Purpose  : Block-in / word-out handshake bundle of the message scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface sha_schedule_if;

    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_word;
    logic [31:0]  k_word;
    logic [5:0]   w_index;
    logic         w_last;

    modport master (
        output blk_valid, blk_data, w_ready,
        input  blk_ready, w_valid, w_word, k_word, w_index, w_last
    );

    modport slave (
        input  blk_valid, blk_data, w_ready,
        output blk_ready, w_valid, w_word, k_word, w_index, w_last
    );

endinterface
`default_nettype wire

// File: rtl/sha_msg_sigma.sv
`default_nettype none
// ============================================================================
// Module   : sha_msg_sigma
// Purpose  : Combinational SHA-256 message-schedule small sigmas s0 and s1.
// Revision : 1.0 - initial release
// ============================================================================
module sha_msg_sigma (
    input  wire logic [31:0] i_x_s0,
    input  wire logic [31:0] i_x_s1,
    output logic      [31:0] o_s0,
    output logic      [31:0] o_s1
);

    assign o_s0 = {i_x_s0[6:0],  i_x_s0[31:7]}
                ^ {i_x_s0[17:0], i_x_s0[31:18]}
                ^ {3'b000, i_x_s0[31:3]};

    assign o_s1 = {i_x_s1[16:0], i_x_s1[31:17]}
                ^ {i_x_s1[18:0], i_x_s1[31:19]}
                ^ {10'b0, i_x_s1[31:10]};

endmodule
`default_nettype wire

// File: rtl/sha_schedule.sv
`default_nettype none
// ============================================================================
// Module   : sha_schedule
// Purpose  : SHA-256 message scheduler; streams W[t]/K[t] for t = 0..63 from
//            a 16-word sliding window, one word per accepted handshake.
// Revision : 1.0 - initial release
// ============================================================================
module sha_schedule
    import sha_schedule_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst_n,
    sha_schedule_if.slave bus
);

    sched_state_t r_state;
    logic [5:0]   r_t;
    logic [31:0]  r_window [16];

    logic        w_valid;
    logic        w_last;
    logic        w_hs;
    logic        w_blk_ready;
    logic        w_accept;
    logic [31:0] w_s0;
    logic [31:0] w_s1;
    logic [31:0] w_next;

    sha_msg_sigma u_sigma (
        .i_x_s0 (r_window[1]),
        .i_x_s1 (r_window[14]),
        .o_s0   (w_s0),
        .o_s1   (w_s1)
    );

    assign w_next      = w_s1 + r_window[9] + w_s0 + r_window[0];
    assign w_valid     = (r_state == ST_RUN);
    assign w_last      = w_valid && (r_t == 6'd63);
    assign w_hs        = w_valid && bus.w_ready;
    // A final-word handshake frees the window, so the next block can land
    // in the same cycle without a bubble.
    assign w_blk_ready = (r_state == ST_IDLE) || (w_hs && w_last);
    assign w_accept    = bus.blk_valid && w_blk_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_t     <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                r_window[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        for (int i = 0; i < 16; i++) begin
                            r_window[i] <= bus.blk_data[511 - 32*i -: 32];
                        end
                        r_t     <= 6'd0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_t <= 6'd0;
                            if (w_accept) begin
                                for (int i = 0; i < 16; i++) begin
                                    r_window[i] <= bus.blk_data[511 - 32*i -: 32];
                                end
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            for (int i = 0; i < 15; i++) begin
                                r_window[i] <= r_window[i+1];
                            end
                            r_window[15] <= w_next;
                            r_t          <= r_t + 6'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.blk_ready = w_blk_ready;
    assign bus.w_valid   = w_valid;
    assign bus.w_last    = w_last;
    assign bus.w_word    = r_window[0];
    assign bus.w_index   = r_t;
    assign bus.k_word    = c_K[r_t];

endmodule
`default_nettype wire

// File: tb/tb_sha_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_schedule
// Purpose  : Scoreboard bench for sha_schedule against a full-array SHA-256
//            schedule model with constants derived from prime cube roots.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha_schedule;

    typedef struct {
        logic [31:0] w;
        logic [31:0] k;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t sb [$];
    logic [31:0] k_ref [64];
    logic abc_mode;
    logic pending_btb;
    logic prev_stall;
    logic [31:0] prev_w, prev_k;
    logic [5:0]  prev_idx;
    logic        prev_last;
    logic rnd_done;

    localparam logic [511:0] c_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};

    sha_schedule_if bus ();

    sha_schedule dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Fractional part of the cube root of the n-th prime, scaled by 2^32.
    task automatic build_k();
        int p;
        int cnt;
        bit is_p;
        real c;
        real f;
        longint v;
        p = 2;
        cnt = 0;
        while (cnt < 64) begin
            is_p = 1'b1;
            for (int d = 2; d * d <= p; d++) if (p % d == 0) is_p = 1'b0;
            if (is_p) begin
                c = $pow(real'(p), 1.0 / 3.0);
                f = c - $floor(c);
                v = longint'($floor(f * 4294967296.0));
                k_ref[cnt] = v[31:0];
                cnt++;
            end
            p++;
        end
    endtask

    function automatic void push_block(input logic [511:0] d);
        logic [31:0] w [64];
        exp_t e;
        for (int t = 0; t < 16; t++) w[t] = d[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10))
                 + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
                 + w[t-16];
        end
        for (int t = 0; t < 64; t++) begin
            e.w = w[t];
            e.k = k_ref[t];
            e.idx = 6'(t);
            e.last = (t == 63);
            sb.push_back(e);
        end
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: pops the scoreboard on every word handshake, checks holds
    // under backpressure, and enqueues a block's words when it is accepted.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall  = 1'b0;
            pending_btb = 1'b0;
        end else begin
            if (pending_btb) begin
                check("no_bubble_valid", {31'b0, bus.w_valid}, 32'd1);
                check("no_bubble_index", {26'b0, bus.w_index}, 32'd0);
                pending_btb = 1'b0;
            end
            if (prev_stall) begin
                check("hold_word",  bus.w_word, prev_w);
                check("hold_k",     bus.k_word, prev_k);
                check("hold_index", {26'b0, bus.w_index}, {26'b0, prev_idx});
                check("hold_last",  {31'b0, bus.w_last}, {31'b0, prev_last});
            end
            prev_stall = bus.w_valid && !bus.w_ready;
            prev_w = bus.w_word;
            prev_k = bus.k_word;
            prev_idx = bus.w_index;
            prev_last = bus.w_last;
            if (bus.w_valid && bus.w_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got index %0d, expected no word", bus.w_index);
                end else begin
                    e = sb.pop_front();
                    check("w_word",  bus.w_word, e.w);
                    check("k_word",  bus.k_word, e.k);
                    check("w_index", {26'b0, bus.w_index}, {26'b0, e.idx});
                    check("w_last",  {31'b0, bus.w_last}, {31'b0, e.last});
                    if (abc_mode) begin
                        case (e.idx)
                            6'd0: begin
                                check("abc_w0", bus.w_word, 32'h61626380);
                                check("k0", bus.k_word, 32'h428a2f98);
                            end
                            6'd15: check("abc_w15", bus.w_word, 32'h00000018);
                            6'd16: check("abc_w16", bus.w_word, 32'h61626380);
                            6'd17: check("abc_w17", bus.w_word, 32'h000F0000);
                            6'd63: check("k63", bus.k_word, 32'hc67178f2);
                            default: ;
                        endcase
                    end
                end
            end
            if (bus.blk_valid && bus.blk_ready) begin
                if (bus.w_valid) begin
                    check("accept_at_63", {26'b0, bus.w_index}, 32'd63);
                    check("accept_with_hs", {31'b0, bus.w_ready}, 32'd1);
                    pending_btb = 1'b1;
                end
                push_block(bus.blk_data);
            end
        end
    end

    task automatic send_block(input logic [511:0] d);
        int n;
        logic acc;
        bus.blk_valid = 1'b1;
        bus.blk_data = d;
        n = 0;
        do begin
            @(negedge clk);
            acc = bus.blk_ready;
            n++;
        end while (!acc && n < 500);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no blk_ready, expected acceptance");
        end
        @(posedge clk);
        #1;
        bus.blk_valid = 1'b0;
        bus.blk_data = rand512();
    endtask

    task automatic wait_idx(input int idx);
        int n;
        n = 0;
        while (!(bus.w_valid && bus.w_index == 6'(idx)) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_index: got timeout, expected index %0d", idx);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d words left, expected 0", sb.size());
        end
        @(negedge clk);
        check("idle_after_last", {31'b0, bus.w_valid}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        abc_mode = 1'b0;
        pending_btb = 1'b0;
        prev_stall = 1'b0;
        rnd_done = 1'b0;
        build_k();
        bus.blk_valid = 1'b0;
        bus.blk_data = '0;
        bus.w_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_blk_ready", {31'b0, bus.blk_ready}, 32'd1);
        check("rst_w_valid",   {31'b0, bus.w_valid}, 32'd0);
        check("rst_w_last",    {31'b0, bus.w_last}, 32'd0);
        check("rst_w_word",    bus.w_word, 32'd0);
        check("rst_w_index",   {26'b0, bus.w_index}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // "abc" block with an ignored block offer and a 3-cycle stall.
        abc_mode = 1'b1;
        send_block(c_ABC);
        wait_idx(10);
        bus.blk_valid = 1'b1;
        bus.blk_data = rand512();
        @(negedge clk);
        check("ignored_blk_ready", {31'b0, bus.blk_ready}, 32'd0);
        @(posedge clk);
        #1 bus.blk_valid = 1'b0;
        wait_idx(20);
        bus.w_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stall_index", {26'b0, bus.w_index}, 32'd20);
        bus.w_ready = 1'b1;
        drain();
        abc_mode = 1'b0;

        // Back-to-back blocks, second offer held through the first.
        send_block(rand512());
        send_block(rand512());
        drain();

        // Random blocks under random backpressure.
        fork
            begin
                for (int b = 0; b < 4; b++) send_block(rand512());
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 bus.w_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.w_ready = 1'b1;
        drain();

        // Reset in the middle of a block, then a fresh "abc" block.
        abc_mode = 1'b1;
        send_block(c_ABC);
        wait_idx(30);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_w_valid",   {31'b0, bus.w_valid}, 32'd0);
        check("midrst_blk_ready", {31'b0, bus.blk_ready}, 32'd1);
        check("midrst_w_word",    bus.w_word, 32'd0);
        check("midrst_w_index",   {26'b0, bus.w_index}, 32'd0);
        check("midrst_w_last",    {31'b0, bus.w_last}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_w_valid",   {31'b0, bus.w_valid}, 32'd0);
        check("post_rst_blk_ready", {31'b0, bus.blk_ready}, 32'd1);
        @(posedge clk);
        #1;
        send_block(c_ABC);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
